// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_controller among NREQ requesters, with
// launch/busy timeouts and per-requester done/err pulses.
module i2c_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [7*NREQ-1:0]  req_addr,
  input  logic [NREQ-1:0]    req_rw,
  input  logic [32*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [NREQ-1:0]    err,
  output logic [31:0]        rdata,
  output logic [6:0]         i2c_addr,
  output logic               i2c_rw,
  output logic [31:0]        i2c_data_out,
  output logic               i2c_enable,
  input  logic [31:0]        i2c_data_in,
  input  logic               i2c_ready
);

  localparam int          PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_t;

  state_t          state, state_nx;
  logic            rdy_meta, rdy_s;
  logic [PW-1:0]   rr_ptr, rr_ptr_nx, win, win_nx;
  logic [15:0]     timer, timer_nx, timer_inc;
  logic [NREQ-1:0] gnt_nx, done_nx, err_nx;
  logic [31:0]     rdata_nx, i2c_data_out_nx;
  logic [6:0]      i2c_addr_nx;
  logic            i2c_rw_nx, i2c_enable_nx;
  logic            pick_found;
  logic [PW-1:0]   pick_idx, cand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_meta <= 1'b0;
      rdy_s    <= 1'b0;
    end else begin
      rdy_meta <= i2c_ready;
      rdy_s    <= rdy_meta;
    end
  end

  // Search starts just after the last served requester, so it ends up lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NREQ);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign timer_inc = (timer == 16'hFFFF) ? timer : timer + 16'd1;

  always_comb begin
    state_nx        = state;
    rr_ptr_nx       = rr_ptr;
    win_nx          = win;
    timer_nx        = timer;
    gnt_nx          = gnt;
    done_nx         = '0;
    err_nx          = '0;
    rdata_nx        = rdata;
    i2c_addr_nx     = i2c_addr;
    i2c_rw_nx       = i2c_rw;
    i2c_data_out_nx = i2c_data_out;
    i2c_enable_nx   = i2c_enable;
    case (state)
      IDLE: begin
        if (pick_found && rdy_s) begin
          win_nx           = pick_idx;
          gnt_nx           = '0;
          gnt_nx[pick_idx] = 1'b1;
          i2c_addr_nx      = req_addr[7*pick_idx +: 7];
          i2c_rw_nx        = req_rw[pick_idx];
          i2c_data_out_nx  = req_wdata[32*pick_idx +: 32];
          i2c_enable_nx    = 1'b1;
          timer_nx         = '0;
          state_nx         = LAUNCH;
        end
      end
      LAUNCH, BUSY: begin
        timer_nx = timer_inc;
        if (timer == TLIM) begin
          i2c_enable_nx = 1'b0;
          err_nx[win]   = 1'b1;
          rr_ptr_nx     = win;
          state_nx      = DONE;
        end else if (state == LAUNCH) begin
          // Enable must be gone before the final ACK or the controller skips STOP.
          if (!rdy_s) begin
            i2c_enable_nx = 1'b0;
            timer_nx      = '0;
            state_nx      = BUSY;
          end
        end else if (rdy_s) begin
          if (i2c_rw) rdata_nx = i2c_data_in;
          done_nx[win] = 1'b1;
          rr_ptr_nx    = win;
          state_nx     = DONE;
        end
      end
      DONE: begin
        gnt_nx   = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= PW'(NREQ - 1);
      win          <= '0;
      timer        <= '0;
      gnt          <= '0;
      done         <= '0;
      err          <= '0;
      rdata        <= '0;
      i2c_addr     <= '0;
      i2c_rw       <= 1'b0;
      i2c_data_out <= '0;
      i2c_enable   <= 1'b0;
    end else begin
      state        <= state_nx;
      rr_ptr       <= rr_ptr_nx;
      win          <= win_nx;
      timer        <= timer_nx;
      gnt          <= gnt_nx;
      done         <= done_nx;
      err          <= err_nx;
      rdata        <= rdata_nx;
      i2c_addr     <= i2c_addr_nx;
      i2c_rw       <= i2c_rw_nx;
      i2c_data_out <= i2c_data_out_nx;
      i2c_enable   <= i2c_enable_nx;
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomized scoreboard bench for i2c_req_arbiter with a behavioural i2c
// controller model and a transaction-level reference of the arbitration rules.
module tb_i2c_req_arbiter;

  localparam int          NREQ      = 4;
  localparam int          TIMEOUT   = 64;
  localparam logic [6:0]  DEAD_ADDR = 7'h78;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [7*NREQ-1:0]  req_addr = '0;
  logic [NREQ-1:0]    req_rw = '0;
  logic [32*NREQ-1:0] req_wdata = '0;
  logic [NREQ-1:0]    gnt, done, err;
  logic [31:0]        rdata;
  logic [6:0]         i2c_addr;
  logic               i2c_rw;
  logic [31:0]        i2c_data_out;
  logic               i2c_enable;
  logic [31:0]        i2c_data_in;
  logic               i2c_ready;

  i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .i2c_addr(i2c_addr), .i2c_rw(i2c_rw), .i2c_data_out(i2c_data_out),
    .i2c_enable(i2c_enable), .i2c_data_in(i2c_data_in), .i2c_ready(i2c_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [6:0]  addr;
    logic        rw;
    logic [31:0] wdata;
    bit          is_err;
    logic [31:0] rdata;
  } exp_t;

  exp_t            exp_q[$];
  int              n_tests = 0;
  int              n_fail = 0;
  logic [31:0]     m_mem [128];
  logic [31:0]     m_rdata = '0;
  int              m_last = NREQ - 1;
  logic [6:0]      a_addr [NREQ];
  logic            a_rw [NREQ];
  logic [31:0]     a_wdata [NREQ];
  logic [NREQ-1:0] pending = '0;
  bit              hold_busy = 1'b0;

  function automatic logic [31:0] mem_init(input int a);
    return 32'hA500_0000 | (a * 32'h0001_0101);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic fail_event(input string name, input logic [31:0] actual);
    n_tests++;
    n_fail++;
    $display("[TB] FAIL %s: observed 0x%0h, expected no event", name, actual);
  endtask

  // Controller model: slave memory, random transfer length, silent on dead addresses.
  logic        c_busy;
  int          c_cnt;
  logic [6:0]  c_addr;
  logic        c_rw;
  logic [31:0] c_wdata;
  logic [31:0] s_mem [128];
  bit          s_written [128];

  assign i2c_ready = !c_busy && !hold_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c_busy      <= 1'b0;
      c_cnt       <= 0;
      i2c_data_in <= '0;
    end else if (!c_busy) begin
      if (i2c_enable && !hold_busy && i2c_addr < DEAD_ADDR) begin
        c_busy      <= 1'b1;
        c_cnt       <= $urandom_range(4, 12);
        c_addr      <= i2c_addr;
        c_rw        <= i2c_rw;
        c_wdata     <= i2c_data_out;
        i2c_data_in <= $urandom;
      end
    end else if (c_cnt > 0) begin
      c_cnt <= c_cnt - 1;
    end else begin
      c_busy <= 1'b0;
      if (c_rw) begin
        i2c_data_in <= s_written[c_addr] ? s_mem[c_addr] : mem_init(int'(c_addr));
      end else begin
        s_mem[c_addr]     <= c_wdata;
        s_written[c_addr] <= 1'b1;
      end
    end
  end

  // Monitor: compares grants and completions against the head of the expectation queue.
  initial begin
    logic [NREQ-1:0] prev_gnt;
    logic            prev_ready;
    int              since;
    exp_t            e;
    prev_gnt   = '0;
    prev_ready = 1'b1;
    since      = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_gnt = '0;
      end else begin
        if (gnt != '0 && prev_gnt == '0) begin
          since = 0;
          if (exp_q.size() == 0) fail_event("unexpected_grant", 32'(gnt));
          else begin
            e = exp_q[0];
            check_output("grant_vec", 32'(gnt), 32'(onehot(e.idx)));
            check_output("grant_addr", 32'(i2c_addr), 32'(e.addr));
            check_output("grant_rw", 32'(i2c_rw), 32'(e.rw));
            check_output("grant_wdata", i2c_data_out, e.wdata);
            check_output("grant_enable", 32'(i2c_enable), 32'd1);
          end
        end else begin
          since++;
        end
        if ((done | err) != '0) begin
          if (exp_q.size() == 0) fail_event("unexpected_completion", 32'(done | err));
          else begin
            e = exp_q.pop_front();
            check_output("done_vec", 32'(done), e.is_err ? 32'd0 : 32'(onehot(e.idx)));
            check_output("err_vec", 32'(err), e.is_err ? 32'(onehot(e.idx)) : 32'd0);
            check_output("rdata", rdata, e.rdata);
            check_output("end_enable", 32'(i2c_enable), 32'd0);
            check_output("held_addr", 32'(i2c_addr), 32'(e.addr));
            if (e.is_err) check_output("timeout_cycles", since, TIMEOUT);
          end
        end
        if (i2c_ready && !prev_ready) check_output("stop_enable_low", 32'(i2c_enable), 32'd0);
        prev_gnt = gnt;
      end
      prev_ready = i2c_ready;
    end
  end

  task automatic drive_fields();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[7*i +: 7]   = a_addr[i];
      req_rw[i]            = a_rw[i];
      req_wdata[32*i +: 32] = a_wdata[i];
    end
  endtask

  task automatic randomize_fields(input logic [NREQ-1:0] set);
    for (int i = 0; i < NREQ; i++) begin
      if (set[i]) begin
        a_addr[i]  = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(120, 127))
                                                 : 7'($urandom_range(0, 15));
        a_rw[i]    = 1'($urandom_range(0, 1));
        a_wdata[i] = $urandom;
      end
    end
  endtask

  task automatic set_field(input int i, input logic [6:0] addr, input logic rw, input logic [31:0] wdata);
    a_addr[i]  = addr;
    a_rw[i]    = rw;
    a_wdata[i] = wdata;
  endtask

  // Reference: all requests of a round are pending together, so they are served
  // in cyclic order starting just after the last requester served.
  task automatic plan_and_drive(input logic [NREQ-1:0] set);
    exp_t e;
    int   last;
    last = m_last;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_last + k) % NREQ;
      if (set[i]) begin
        e.idx    = i;
        e.addr   = a_addr[i];
        e.rw     = a_rw[i];
        e.wdata  = a_wdata[i];
        e.is_err = (a_addr[i] >= DEAD_ADDR);
        if (!e.is_err) begin
          if (e.rw) m_rdata = m_mem[e.addr];
          else      m_mem[e.addr] = e.wdata;
        end
        e.rdata = m_rdata;
        exp_q.push_back(e);
        last = i;
      end
    end
    m_last = last;
    drive_fields();
    req     = set;
    pending = set;
  endtask

  task automatic wait_round();
    int budget;
    budget = NREQ * (TIMEOUT + 60);
    while (pending != '0 && budget > 0) begin
      @(negedge clk);
      budget--;
      pending = pending & ~(done | err);
      req     = req & ~(done | err);
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && req[i] && $urandom_range(0, 1) == 1) begin
          req[i]    = 1'b0;
          a_addr[i] = 7'($urandom);
          a_wdata[i] = $urandom;
          drive_fields();
        end
      end
    end
    if (pending != '0) begin
      check_output("round_complete", 32'(pending), 32'd0);
      req     = '0;
      pending = '0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [NREQ-1:0] set);
    plan_and_drive(set);
    @(negedge clk);
    check_output("grant_latency", 32'(gnt), 32'(onehot(exp_q[0].idx)));
    wait_round();
  endtask

  task automatic check_reset_outputs();
    check_output("rst_gnt", 32'(gnt), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    check_output("rst_enable", 32'(i2c_enable), 32'd0);
    check_output("rst_rdata", rdata, 32'd0);
    check_output("rst_addr", 32'(i2c_addr), 32'd0);
    check_output("rst_rw", 32'(i2c_rw), 32'd0);
    check_output("rst_data_out", i2c_data_out, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int budget;
    for (int a = 0; a < 128; a++) m_mem[a] = mem_init(a);
    for (int i = 0; i < NREQ; i++) set_field(i, 7'h0, 1'b0, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single write, write/read of a known word, rdata held across a write, timeout.
    set_field(0, 7'h50, 1'b0, 32'hDEAD_BEEF); apply_stimulus(4'b0001);
    set_field(2, 7'h21, 1'b0, 32'h1234_5678); apply_stimulus(4'b0100);
    set_field(2, 7'h21, 1'b1, 32'h0);         apply_stimulus(4'b0100);
    set_field(0, 7'h50, 1'b0, $urandom);      apply_stimulus(4'b0001);
    set_field(1, 7'h7F, 1'b1, 32'h0);         apply_stimulus(4'b0010);

    // Everyone requesting at once, then a partial set.
    for (int i = 0; i < NREQ; i++) set_field(i, 7'(i + 1), 1'b0, $urandom);
    apply_stimulus(4'b1111);
    randomize_fields(4'b0011); apply_stimulus(4'b0011);

    // Controller busy at IDLE: no grant until the synchronised ready returns.
    hold_busy = 1'b1;
    repeat (4) @(negedge clk);
    randomize_fields(4'b1000);
    plan_and_drive(4'b1000);
    repeat (5) begin
      @(negedge clk);
      check_output("no_grant_ready_low", 32'(gnt), 32'd0);
    end
    hold_busy = 1'b0;
    repeat (2) @(negedge clk);
    check_output("grant_waits_sync", 32'(gnt), 32'd0);
    @(negedge clk);
    check_output("grant_after_sync", 32'(gnt), 32'(onehot(3)));
    wait_round();

    // Reset while requester 1 is in the middle of a transfer.
    randomize_fields(4'b0010);
    set_field(1, 7'h05, 1'b1, 32'h0);
    plan_and_drive(4'b0010);
    budget = 200;
    while (!(gnt[1] && !i2c_enable) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_output("busy_reached", 32'(gnt), 32'(onehot(1)));
    rst = 1'b1;
    #1;
    check_reset_outputs();
    exp_q.delete();
    m_last  = NREQ - 1;
    m_rdata = '0;
    req     = '0;
    pending = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    randomize_fields(4'b1011); apply_stimulus(4'b1011);

    for (int r = 0; r < 40; r++) begin
      logic [NREQ-1:0] set;
      set = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      randomize_fields(set);
      apply_stimulus(set);
    end

    repeat (5) @(negedge clk);
    check_output("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
